serdes_sipo_piso_fifo: RTL and testbench

- Parametrised single-clock successor to the fixed 8-bit serial-to-parallel-to-serial path.
- Serial input beats of LANES bits are deserialised into DATA_W-bit words, buffered in a FIFO_DEPTH-entry word FIFO, then reserialised onto LANES-bit output beats.
- Valid/ready handshake on both serial sides; FIFO level is exported for link monitoring.
- Sits between a lane-rate front end and a lane-rate back end that run at different effective rates on one clock.

---
 rtl/serdes_sipo_piso_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_serdes_sipo_piso_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_sipo_piso_fifo.sv
// Serial-to-parallel, word FIFO, parallel-to-serial path with valid/ready on both lane sides.
// Build option: define SERDES_PARITY_EN to append an even-parity beat to every output word.
module serdes_sipo_piso_fifo #(
    parameter int DATA_W     = 8,
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          flush_i,
    input  logic [LANES-1:0]              s_data_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic [LANES-1:0]              m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    // state     | meaning
    // ST_IDLE   | no word loaded; pops the FIFO head when one is available
    // ST_SHIFT  | driving data beats of the loaded word
    // ST_PARITY | driving the trailing parity beat (SERDES_PARITY_EN builds only)

    localparam int BEATS = DATA_W / LANES;
    localparam int CNT_W = $clog2(BEATS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifdef SERDES_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    logic [CNT_W-1:0]        in_cnt;
    logic [DATA_W-LANES-1:0] in_sh;
    logic [DATA_W-1:0]       in_word;
    logic                    in_last, in_fire, push;

    logic [DATA_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [LVL_W-1:0]        level;
    logic                    full, empty, pop;

    state_t                  state, state_nxt;
    logic [DATA_W-1:0]       out_sh;
    logic [CNT_W-1:0]        out_idx;
    logic [LANES-1:0]        beat_cur;
    logic                    load, adv;

    // ---------------- SIPO ----------------
    assign in_last   = (in_cnt == LAST_BEAT);
    assign full      = (level == LVL_W'(FIFO_DEPTH));
    assign empty     = (level == '0);
    // Registered-state only: a same-cycle pop never makes room for this cycle's push.
    assign s_ready_o = !(in_last && full);
    assign in_fire   = s_valid_i && s_ready_o && !flush_i;
    assign push      = in_fire && in_last;

    generate
        if (MSB_FIRST != 0) begin : g_in_msb
            assign in_word = {in_sh, s_data_i};
        end else begin : g_in_lsb
            assign in_word = {s_data_i, in_sh};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_cnt <= '0;
            in_sh  <= '0;
        end else if (flush_i) begin
            in_cnt <= '0;
            in_sh  <= '0;
        end else if (in_fire) begin
            in_cnt <= in_last ? '0 : in_cnt + 1'b1;
            in_sh  <= (MSB_FIRST != 0) ? in_word[DATA_W-LANES-1:0] : in_word[DATA_W-1:LANES];
        end
    end

    // ---------------- word FIFO ----------------
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign fifo_level_o = level;

    // ---------------- PISO ----------------
    generate
        if (MSB_FIRST != 0) begin : g_out_msb
            assign beat_cur = out_sh[DATA_W-1 -: LANES];
        end else begin : g_out_lsb
            assign beat_cur = out_sh[LANES-1:0];
        end
    endgenerate

`ifdef SERDES_PARITY_EN
    logic             out_par;
    logic [LANES-1:0] par_beat;

    always_comb begin
        par_beat    = '0;
        par_beat[0] = out_par;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        m_valid_o = 1'b0;
        m_data_o  = '0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                m_valid_o = 1'b1;
                m_data_o  = beat_cur;
                if (m_ready_i) begin
                    if (out_idx != LAST_BEAT) begin
                        adv = 1'b1;
                    end else begin
`ifdef SERDES_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        // Reload straight from the FIFO so consecutive words leave without a bubble.
                        if (!empty) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
`endif
                    end
                end
            end
`ifdef SERDES_PARITY_EN
            ST_PARITY: begin
                m_valid_o = 1'b1;
                m_data_o  = par_beat;
                if (m_ready_i) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        load      = 1'b1;
                        state_nxt = ST_SHIFT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
        if (flush_i) begin
            state_nxt = ST_IDLE;
            pop       = 1'b0;
            load      = 1'b0;
            adv       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_sh  <= '0;
            out_idx <= '0;
`ifdef SERDES_PARITY_EN
            out_par <= 1'b0;
`endif
        end else if (load) begin
            out_sh  <= mem[rd_ptr];
            out_idx <= '0;
`ifdef SERDES_PARITY_EN
            out_par <= ^mem[rd_ptr];
`endif
        end else if (adv) begin
            out_sh  <= (MSB_FIRST != 0) ? (out_sh << LANES) : (out_sh >> LANES);
            out_idx <= out_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_serdes_sipo_piso_fifo.sv
// Directed bench for serdes_sipo_piso_fifo: an 8x1 instance for the main path and an 8x2 instance for the parity beat.
module tb_serdes_sipo_piso_fifo;

`ifdef SERDES_PARITY_EN
    localparam int BPW  = 9;
    localparam int BPW2 = 5;
`else
    localparam int BPW  = 8;
    localparam int BPW2 = 4;
`endif

    logic       clk_i = 1'b0;
    logic       rst_n_i, flush_i;
    logic [0:0] s_data_i;
    logic       s_valid_i, s_ready_o;
    logic [0:0] m_data_o;
    logic       m_valid_o, m_ready_i;
    logic [2:0] fifo_level_o;

    logic [1:0] s2_data, m2_data;
    logic       s2_valid, s2_ready, m2_valid, m2_ready;
    logic [2:0] lvl2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int over1 = 0;
    logic       q1[$];
    int         qc[$];
    logic [1:0] q2[$];

    always #5 clk_i = ~clk_i;

    serdes_sipo_piso_fifo #(.DATA_W(8), .LANES(1), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .fifo_level_o(fifo_level_o)
    );

    serdes_sipo_piso_fifo #(.DATA_W(8), .LANES(2), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut2 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .s_data_i(s2_data), .s_valid_i(s2_valid), .s_ready_o(s2_ready),
        .m_data_o(m2_data), .m_valid_o(m2_valid), .m_ready_i(m2_ready),
        .fifo_level_o(lvl2)
    );

    // Record every consumed output beat and the cycle it was consumed in.
    always @(negedge clk_i) begin
        cyc++;
        if (rst_n_i && !flush_i) begin
            if (m_valid_o && m_ready_i) begin
                q1.push_back(m_data_o[0]);
                qc.push_back(cyc);
            end
            if (m2_valid && m2_ready) q2.push_back(m2_data);
        end
        if (fifo_level_o > 3'd1) over1++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            s_data_i  = w[i];
            s_valid_i = 1'b1;
            step();
        end
        s_valid_i = 1'b0;
        s_data_i  = 1'b0;
    endtask

    task automatic check_word(input string tag, input int idx, input logic [7:0] exp);
        logic [7:0] w;
        logic       ok;
        w  = '0;
        ok = (q1.size() >= idx + BPW);
        check({tag, "_avail"}, 32'(ok), 32'd1);
        if (ok) begin
            for (int i = 0; i < 8; i++) w = {w[6:0], q1[idx+i]};
            check(tag, 32'(w), 32'(exp));
`ifdef SERDES_PARITY_EN
            check({tag, "_par"}, 32'(q1[idx+8]), 32'(^exp));
`endif
        end
    endtask

    logic [7:0] words [10];
    logic [7:0] full_words [5];
    int base, o1;

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0; s_valid_i = 1'b0; s_data_i = 1'b0; m_ready_i = 1'b1;
        s2_valid = 1'b0; s2_data = 2'b00; m2_ready = 1'b1;
        full_words[0] = 8'hA5; full_words[1] = 8'h3C; full_words[2] = 8'hFF;
        full_words[3] = 8'h00; full_words[4] = 8'h81;

        // reset state
        #3;
        check("rst_m_valid", 32'(m_valid_o), 32'd0);
        check("rst_m_data", 32'(m_data_o), 32'd0);
        check("rst_level", 32'(fifo_level_o), 32'd0);
        check("rst_m2_valid", 32'(m2_valid), 32'd0);
        #10 rst_n_i = 1'b1;
        step();
        check("rst_s_ready", 32'(s_ready_o), 32'd1);

        // single word, latency and level trace
        base = q1.size();
        send_word(8'hB2);
        check("t1_level_after_push", 32'(fifo_level_o), 32'd1);
        check("t1_valid_at_T", 32'(m_valid_o), 32'd0);
        step();
        check("t1_valid_at_T1", 32'(m_valid_o), 32'd1);
        check("t1_level_after_pop", 32'(fifo_level_o), 32'd0);
        check("t1_first_beat", 32'(m_data_o), 32'd1);
        repeat (10) step();
        check_word("t1_word", base, 8'hB2);
        check("t1_beats", 32'(q1.size() - base), 32'(BPW));

        // back-to-back words
        base = q1.size();
        o1   = over1;
        for (int i = 0; i < 10; i++) words[i] = 8'($urandom);
        for (int i = 0; i < 10; i++) send_word(words[i]);
        repeat (20) step();
        check("t2_beats", 32'(q1.size() - base), 32'(10 * BPW));
        if (q1.size() - base == 10 * BPW)
            check("t2_no_gap", 32'(qc[base + 10*BPW - 1] - qc[base]), 32'(10 * BPW - 1));
        for (int i = 0; i < 10; i++) check_word("t2_word", base + i * BPW, words[i]);
`ifndef SERDES_PARITY_EN
        check("t2_level_max1", 32'(over1 - o1), 32'd0);
`endif

        // fill to full with the output stalled
        m_ready_i = 1'b0;
        base = q1.size();
        for (int i = 0; i < 5; i++) send_word(full_words[i]);
        check("t3_level_full", 32'(fifo_level_o), 32'd4);
        check("t3_piso_valid", 32'(m_valid_o), 32'd1);
        check("t3_piso_head", 32'(m_data_o), 32'd1);
        for (int i = 0; i < 7; i++) begin
            s_data_i = 1'b0; s_valid_i = 1'b1;
            step();
        end
        check("t3_s_ready_full", 32'(s_ready_o), 32'd0);
        step();
        check("t3_level_held", 32'(fifo_level_o), 32'd4);
        s_valid_i = 1'b0;
        m_ready_i = 1'b1;
        repeat (5 * BPW + 10) step();
        check("t3_beats", 32'(q1.size() - base), 32'(5 * BPW));
        for (int i = 0; i < 5; i++) check_word("t3_word", base + i * BPW, full_words[i]);
        check("t3_level_drained", 32'(fifo_level_o), 32'd0);
        check("t3_s_ready_back", 32'(s_ready_o), 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;

        // flush with a partial input word and an output word in flight
        send_word(8'hC3);
        for (int i = 0; i < 3; i++) begin
            s_data_i = 1'b1; s_valid_i = 1'b1;
            step();
        end
        check("t4_mid_word_valid", 32'(m_valid_o), 32'd1);
        s_data_i = 1'b0;
        flush_i  = 1'b1;
        step();
        flush_i   = 1'b0;
        s_valid_i = 1'b0;
        check("t4_flush_valid", 32'(m_valid_o), 32'd0);
        check("t4_flush_level", 32'(fifo_level_o), 32'd0);
        check("t4_flush_data", 32'(m_data_o), 32'd0);
        base = q1.size();
        send_word(8'h5A);
        repeat (12) step();
        check_word("t4_word", base, 8'h5A);
        check("t4_beats", 32'(q1.size() - base), 32'(BPW));

        // asynchronous reset between edges
        m_ready_i = 1'b0;
        send_word(8'h96);
        send_word(8'h69);
        for (int i = 0; i < 3; i++) begin
            s_data_i = 1'b1; s_valid_i = 1'b1;
            step();
        end
        check("t5_pre_valid", 32'(m_valid_o), 32'd1);
        check("t5_pre_level", 32'(fifo_level_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check("t5_async_valid", 32'(m_valid_o), 32'd0);
        check("t5_async_data", 32'(m_data_o), 32'd0);
        check("t5_async_level", 32'(fifo_level_o), 32'd0);
        s_valid_i = 1'b0;
        s_data_i  = 1'b0;
        m_ready_i = 1'b1;
        #3 rst_n_i = 1'b1;
        step();
        check("t5_s_ready", 32'(s_ready_o), 32'd1);
        base = q1.size();
        send_word(8'h3C);
        repeat (12) step();
        check_word("t5_word", base, 8'h3C);
        check("t5_beats", 32'(q1.size() - base), 32'(BPW));

        // two-lane word 0x07: beats 00,00,01,11 (+ parity 01 when enabled)
        s2_valid = 1'b1;
        s2_data = 2'b00; step();
        s2_data = 2'b00; step();
        s2_data = 2'b01; step();
        s2_data = 2'b11; step();
        s2_valid = 1'b0;
        s2_data  = 2'b00;
        repeat (10) step();
        check("t6_beats", 32'(q2.size()), 32'(BPW2));
        check("t6_beat0", 32'(q2[0]), 32'd0);
        check("t6_beat1", 32'(q2[1]), 32'd0);
        check("t6_beat2", 32'(q2[2]), 32'd1);
        check("t6_beat3", 32'(q2[3]), 32'd3);
`ifdef SERDES_PARITY_EN
        check("t6_parity", 32'(q2[4]), 32'd1);
`endif
        check("t6_level", 32'(lvl2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
